// File: rtl/sqrt_operand_sequencer.sv
// -----------------------------------------------------------------------------
// sqrt_operand_sequencer
//
// Front end for an iterative IEEE754 single-precision square-root core.
// Operands are accepted one at a time. Special operands (NaN, negatives, zeros,
// +inf, denormals) are answered here without touching the core. Normal operands
// restart the core with a CLR_CYCLES-long active-low pulse on core_RST, then
// wait for the core's done level and hold the result for the consumer.
//
// Optional feature: define SQRT_WATCHDOG_EN to add an 8-bit RUN watchdog. When
// it expires, the block returns a quiet NaN with the timeout flag set. Without
// the macro there is no watchdog logic, RUN waits forever, and out_flags[0] is
// tied to 0.
//
// Handshake semantics (both sides): a transfer happens on a rising CLK edge
// where valid and ready are both high. A producer holds valid and its data
// until that transfer. in_ready is high only in IDLE. out_valid is high only
// in HOLD, where out_data/out_flags are frozen until the transfer. out_ready
// seen without out_valid does nothing.
//
// Parameters:
//   CLR_CYCLES  cycles core_RST is held low before each core run (>= 1)
//   TIMEOUT     watchdog limit in RUN cycles (1..255, used with SQRT_WATCHDOG_EN)
//
// Ports:
//   CLK, RST        clock, asynchronous active-low reset
//   in_valid/in_ready/in_data     operand input handshake
//   core_A, core_RST              operand and active-low restart to the core
//   core_result, core_overflow, core_underflow, core_enable   core outputs
//   out_valid/out_ready/out_data  result output handshake
//   out_flags       {invalid, overflow, underflow, timeout}
//   fsm_state       debug view of the sequencer state
// -----------------------------------------------------------------------------
module sqrt_operand_sequencer #(
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic [31:0] core_A,
    output logic        core_RST,
    input  logic [31:0] core_result,
    input  logic        core_overflow,
    input  logic        core_underflow,
    input  logic        core_enable,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_flags,
    output logic [2:0]  fsm_state
);

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam int          CLR_W   = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    // Elaboration-time guard on parameter ranges.
    if (CLR_CYCLES < 1 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
        $error("sqrt_operand_sequencer: CLR_CYCLES must be >= 1 and TIMEOUT in 1..255");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BYPASS = 3'd1,
        CLEAR  = 3'd2,
        RUN    = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t             state;
    logic [CLR_W-1:0]   clr_cnt;
    logic [3:1]         flag_q;      // {invalid, overflow, underflow}

    // ------------------------------------------------------------------
    // Operand classification (combinational, used on the accepting edge)
    // ------------------------------------------------------------------
    logic [7:0]  op_exp;
    logic [22:0] op_frac;
    logic        op_sign;
    logic        cls_special;
    logic [31:0] cls_data;
    logic [3:1]  cls_flags;

    assign op_sign = in_data[31];
    assign op_exp  = in_data[30:23];
    assign op_frac = in_data[22:0];

    // Priority order matters: NaN first, then any negative nonzero value
    // (so -inf and negative denormals are invalid), then zeros, +inf and
    // positive denormals.
    always_comb begin
        cls_special = 1'b1;
        cls_data    = 32'h0;
        cls_flags   = 3'b000;
        if (op_exp == 8'hFF && op_frac != 23'd0) begin
            cls_data  = QNAN;
            cls_flags = 3'b100;
        end else if (op_sign && (op_exp != 8'd0 || op_frac != 23'd0)) begin
            cls_data  = QNAN;
            cls_flags = 3'b100;
        end else if (op_exp == 8'd0 && op_frac == 23'd0) begin
            cls_data  = in_data;
        end else if (op_exp == 8'hFF) begin
            cls_data  = POS_INF;
        end else if (op_exp == 8'd0) begin
            cls_data  = {op_sign, 31'd0};
            cls_flags = 3'b001;
        end else begin
            cls_special = 1'b0;
        end
    end

`ifdef SQRT_WATCHDOG_EN
    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];
    logic [7:0] wd_cnt;
    logic       timeout_q;
    assign out_flags = {flag_q, timeout_q};
`else
    assign out_flags = {flag_q, 1'b0};
`endif

    assign fsm_state = state;

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 32'h0;
            flag_q    <= 3'b000;
            core_A    <= 32'h0;
            core_RST  <= 1'b0;
            clr_cnt   <= '0;
`ifdef SQRT_WATCHDOG_EN
            wd_cnt    <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    core_RST <= 1'b1;
                    if (in_valid && in_ready) begin
                        core_A   <= in_data;
                        in_ready <= 1'b0;
`ifdef SQRT_WATCHDOG_EN
                        timeout_q <= 1'b0;
`endif
                        if (cls_special) begin
                            out_data <= cls_data;
                            flag_q   <= cls_flags;
                            state    <= BYPASS;
                        end else begin
                            // core_RST drops on this edge; the down-counter
                            // makes the low pulse exactly CLR_CYCLES long.
                            core_RST <= 1'b0;
                            clr_cnt  <= CLR_W'(CLR_CYCLES - 1);
                            state    <= CLEAR;
                        end
                    end
                end

                BYPASS: begin
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end

                CLEAR: begin
                    if (clr_cnt == '0) begin
                        core_RST <= 1'b1;
                        state    <= RUN;
`ifdef SQRT_WATCHDOG_EN
                        wd_cnt   <= 8'd0;
`endif
                    end else begin
                        clr_cnt <= clr_cnt - CLR_W'(1);
                    end
                end

                RUN: begin
                    // A done level left over from an earlier run cannot reach
                    // here: CLEAR has just reset the core.
                    if (core_enable) begin
                        out_data  <= core_result;
                        flag_q    <= {1'b0, core_overflow, core_underflow};
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
`ifdef SQRT_WATCHDOG_EN
                    else if (wd_cnt == TIMEOUT_CNT) begin
                        out_data  <= QNAN;
                        flag_q    <= 3'b000;
                        timeout_q <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
`endif
                end

                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sqrt_operand_sequencer
//
// Directed bench for sqrt_operand_sequencer. A small behavioural core model
// raises core_enable a fixed number of cycles after core_RST goes high and
// keeps it high until the next core reset, so a stale done level is present
// whenever a new normal run starts. Define SQRT_WATCHDOG_EN for both files to
// exercise the watchdog scenario.
// -----------------------------------------------------------------------------
module tb_sqrt_operand_sequencer;

    localparam int CLR_CYCLES = 2;
    localparam int TIMEOUT    = 255;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic [31:0] core_A;
    logic        core_RST;
    logic [31:0] core_result = 32'h0;
    logic        core_overflow = 1'b0;
    logic        core_underflow = 1'b0;
    logic        core_enable = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_flags;
    logic [2:0]  fsm_state;

    int n_cmp = 0;
    int n_bad = 0;

    // core model controls
    logic [31:0] core_res  = 32'h0;
    logic        core_ovf  = 1'b0;
    int          core_lat  = 20;
    logic        core_stuck = 1'b0;
    int          core_cnt  = 0;

    sqrt_operand_sequencer #(
        .CLR_CYCLES(CLR_CYCLES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .core_A        (core_A),
        .core_RST      (core_RST),
        .core_result   (core_result),
        .core_overflow (core_overflow),
        .core_underflow(core_underflow),
        .core_enable   (core_enable),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_flags     (out_flags),
        .fsm_state     (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- core model ----------------
    always @(posedge CLK) begin
        if (!core_RST) begin
            core_cnt    <= 0;
            core_enable <= 1'b0;
        end else if (!core_stuck && !core_enable) begin
            if (core_cnt == core_lat) begin
                core_enable    <= 1'b1;
                core_result    <= core_res;
                core_overflow  <= core_ovf;
                core_underflow <= 1'b0;
            end else begin
                core_cnt <= core_cnt + 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_op(input logic [31:0] d);
        int k;
        @(negedge CLK);
        in_data  = d;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge CLK);
            k++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_wait: in_ready=%b required 1 within 50 cycles", in_ready);
        end
        @(posedge CLK);
        #1 in_valid = 1'b0;
    endtask

    // Counts negedges after the accepting edge until out_valid is seen;
    // cycle 1 is the one immediately following the accepting edge.
    task automatic wait_result(input int budget, output int cyc, output int rst_low);
        cyc = 0;
        rst_low = 0;
        do begin
            @(negedge CLK);
            cyc++;
            if (!core_RST) rst_low++;
        end while (!out_valid && cyc < budget);
        if (!out_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL result_wait: out_valid=%b required 1 within %0d cycles", out_valid, budget);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({in_ready, out_valid, core_RST} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_ctrl: {in_ready,out_valid,core_RST}=%b required 000", {in_ready, out_valid, core_RST});
        end
        n_cmp++;
        if ({out_data, core_A, out_flags} !== 68'h0) begin
            n_bad++;
            $display("FAIL reset_data: out_data=%h core_A=%h out_flags=%b required all 0", out_data, core_A, out_flags);
        end
        RST = 1'b1;
        @(posedge CLK);
        #1;
        n_cmp++;
        if ({in_ready, core_RST} !== 2'b11) begin
            n_bad++;
            $display("FAIL reset_release: {in_ready,core_RST}=%b required 11", {in_ready, core_RST});
        end
    endtask

    task automatic test_normal();
        int cyc, low;
        core_res = 32'h4000_0000;
        core_ovf = 1'b0;
        core_lat = 20;
        send_op(32'h4080_0000);
        wait_result(100, cyc, low);
        n_cmp++;
        if (low !== CLR_CYCLES) begin
            n_bad++;
            $display("FAIL normal_clr_len: core_RST low %0d cycles required %0d", low, CLR_CYCLES);
        end
        n_cmp++;
        if (out_data !== 32'h4000_0000 || out_flags !== 4'b0000) begin
            n_bad++;
            $display("FAIL normal_result: data=%h flags=%b required 40000000/0000", out_data, out_flags);
        end
        n_cmp++;
        if (core_A !== 32'h4080_0000) begin
            n_bad++;
            $display("FAIL normal_core_a: core_A=%h required 40800000", core_A);
        end
        @(negedge CLK);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL normal_return: {out_valid,in_ready}=%b required 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_bypass_negative();
        int cyc, low;
        send_op(32'hC080_0000);
        wait_result(20, cyc, low);
        n_cmp++;
        if (cyc !== 2) begin
            n_bad++;
            $display("FAIL neg_latency: out_valid after %0d cycles required 2", cyc);
        end
        n_cmp++;
        if (low !== 0) begin
            n_bad++;
            $display("FAIL neg_no_restart: core_RST low %0d cycles required 0", low);
        end
        n_cmp++;
        if (out_data !== 32'h7FC0_0000 || out_flags !== 4'b1000) begin
            n_bad++;
            $display("FAIL neg_result: data=%h flags=%b required 7fc00000/1000", out_data, out_flags);
        end
        @(negedge CLK);
    endtask

    task automatic test_specials();
        logic [31:0] op   [3];
        logic [31:0] exp_d[3];
        logic [3:0]  exp_f[3];
        int cyc, low;
        op[0] = 32'h8000_0000; exp_d[0] = 32'h8000_0000; exp_f[0] = 4'b0000;
        op[1] = 32'h7F80_0000; exp_d[1] = 32'h7F80_0000; exp_f[1] = 4'b0000;
        op[2] = 32'h0000_0001; exp_d[2] = 32'h0000_0000; exp_f[2] = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            send_op(op[i]);
            wait_result(20, cyc, low);
            n_cmp++;
            if (out_data !== exp_d[i] || out_flags !== exp_f[i] || cyc !== 2 || low !== 0) begin
                n_bad++;
                $display("FAIL special_%0d: data=%h flags=%b cyc=%0d rstlow=%0d required %h/%b cyc=2 rstlow=0",
                         i, out_data, out_flags, cyc, low, exp_d[i], exp_f[i]);
            end
            @(negedge CLK);
        end
    endtask

    // The core still holds core_enable high with the old result from the
    // previous normal run; a correct block must wait for the new result.
    task automatic test_core_flags_stale_enable();
        int cyc, low;
        core_res = 32'h5F35_04F3;
        core_ovf = 1'b1;
        core_lat = 6;
        send_op(32'h7E00_0000);
        wait_result(60, cyc, low);
        n_cmp++;
        if (out_data !== 32'h5F35_04F3 || out_flags !== 4'b0100) begin
            n_bad++;
            $display("FAIL core_flags: data=%h flags=%b required 5f3504f3/0100", out_data, out_flags);
        end
        n_cmp++;
        if (cyc <= CLR_CYCLES + 1) begin
            n_bad++;
            $display("FAIL stale_enable: result after %0d cycles required more than %0d", cyc, CLR_CYCLES + 1);
        end
        core_ovf = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_hold_backpressure();
        int cyc, low, hs;
        core_res  = 32'h4040_0000;
        core_lat  = 5;
        out_ready = 1'b0;
        send_op(32'h4110_0000);
        wait_result(60, cyc, low);
        in_data  = 32'h3F80_0000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            n_cmp++;
            if (out_data !== 32'h4040_0000 || out_valid !== 1'b1 || in_ready !== 1'b0 || core_A !== 32'h4110_0000) begin
                n_bad++;
                $display("FAIL hold_stable_%0d: data=%h valid=%b in_ready=%b core_A=%h required 40400000/1/0/41100000",
                         i, out_data, out_valid, in_ready, core_A);
            end
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        hs = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            if (out_valid && out_ready) hs++;
            @(negedge CLK);
        end
        n_cmp++;
        if (hs !== 1 || out_valid !== 1'b0 || in_ready !== 1'b1 || core_A !== 32'h4110_0000) begin
            n_bad++;
            $display("FAIL hold_release: handshakes=%0d valid=%b in_ready=%b core_A=%h required 1/0/1/41100000",
                     hs, out_valid, in_ready, core_A);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc, low;
        core_res = 32'h4000_0000;
        core_lat = 20;
        send_op(32'h4080_0000);
        repeat (5) @(negedge CLK);
        n_cmp++;
        if ({core_RST, out_valid} !== 2'b10) begin
            n_bad++;
            $display("FAIL midrun_pre: {core_RST,out_valid}=%b required 10", {core_RST, out_valid});
        end
        #2 RST = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, core_RST, out_flags} !== 7'b0 || out_data !== 32'h0 || core_A !== 32'h0) begin
            n_bad++;
            $display("FAIL midrun_reset: in_ready=%b valid=%b core_RST=%b flags=%b data=%h core_A=%h required all 0",
                     in_ready, out_valid, core_RST, out_flags, out_data, core_A);
        end
        @(negedge CLK);
        RST = 1'b1;
        core_res = 32'h4080_0000;
        send_op(32'h4180_0000);
        wait_result(100, cyc, low);
        n_cmp++;
        if (out_data !== 32'h4080_0000 || out_flags !== 4'b0000 || low !== CLR_CYCLES) begin
            n_bad++;
            $display("FAIL midrun_after: data=%h flags=%b rstlow=%0d required 40800000/0000/%0d",
                     out_data, out_flags, low, CLR_CYCLES);
        end
        @(negedge CLK);
    endtask

`ifdef SQRT_WATCHDOG_EN
    task automatic test_watchdog();
        int cyc, low;
        core_stuck = 1'b1;
        send_op(32'h4080_0000);
        wait_result(TIMEOUT + CLR_CYCLES + 40, cyc, low);
        n_cmp++;
        if (cyc !== TIMEOUT + CLR_CYCLES + 2) begin
            n_bad++;
            $display("FAIL wd_latency: out_valid after %0d cycles required %0d", cyc, TIMEOUT + CLR_CYCLES + 2);
        end
        n_cmp++;
        if (out_data !== 32'h7FC0_0000 || out_flags !== 4'b0001) begin
            n_bad++;
            $display("FAIL wd_result: data=%h flags=%b required 7fc00000/0001", out_data, out_flags);
        end
        core_stuck = 1'b0;
        @(negedge CLK);
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_normal();
        test_bypass_negative();
        test_specials();
        test_core_flags_stale_enable();
        test_hold_backpressure();
        test_reset_mid_run();
`ifdef SQRT_WATCHDOG_EN
        test_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded 200000 time units");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/sqrt_operand_sequencer.md
SQRT_OPERAND_SEQUENCER -- requirements
Module: sqrt_operand_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named as the codebase does: CLK and RST.
REQ-002 The block SHALL have the following parameters:
- CLR_CYCLES, default 2: number of cycles core_RST is held low before each run.
- TIMEOUT, default 255: watchdog limit in cycles. Used only when SQRT_WATCHDOG_EN is defined.
REQ-003 The block SHALL have the following ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous active-low reset
- in_valid  input  1  operand offered
- in_ready  output  1  block can accept an operand
- in_data  input  32  IEEE754 single operand
- core_A  output  32  operand driven to the square-root core, held stable during a run
- core_RST  output  1  active-low restart to the core
- core_result  input  32  core result
- core_overflow  input  1  core overflow flag
- core_underflow  input  1  core underflow flag
- core_enable  input  1  core done, level
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts the result
- out_data  output  32  IEEE754 result
- out_flags  output  4  {invalid, overflow, underflow, timeout}

Function
REQ-004 The FSM SHALL have the states IDLE, BYPASS, CLEAR, RUN and HOLD.
REQ-005 A handshake in_valid&in_ready SHALL occur only in IDLE. On that handshake the block SHALL register in_data into core_A and classify the operand in the same cycle.
REQ-006 Classification SHALL be:
- NaN (exp=FF, frac≠0): result 0x7FC00000, invalid=1.
- Negative nonzero, including -inf: result 0x7FC00000, invalid=1.
- ±0: result in_data unchanged.
- +inf: result 0x7F800000.
- Denormal (exp=0, frac≠0): result +0 carrying the sign of in_data, underflow=1.
- Otherwise: normal.
REQ-007 Special operands SHALL go IDLE->BYPASS->HOLD. out_valid SHALL assert 2 cycles after the accepting edge, and the core SHALL NOT be restarted.
REQ-008 Normal operands SHALL go IDLE->CLEAR. In CLEAR, core_RST SHALL be 0 for exactly CLR_CYCLES cycles, counted by a down-counter, then the FSM SHALL go to RUN.
REQ-009 In RUN, core_RST SHALL be 1. The first cycle with core_enable=1 SHALL capture core_result, core_overflow and core_underflow into out_data/out_flags and go to HOLD.
REQ-010 core_enable SHALL be ignored outside RUN. A core_enable still high from a previous run SHALL NOT complete a new run, because CLEAR forces the core to reset.
REQ-011 In HOLD, out_valid=1. out_data and out_flags SHALL stay stable until out_valid&out_ready.
REQ-012 On the HOLD handshake the FSM SHALL go to IDLE. in_ready SHALL be 1 only in IDLE, so there is no same-cycle re-accept.
REQ-013 out_ready asserted before out_valid SHALL have no effect.
REQ-014 core_A SHALL change only on an IDLE accept.
REQ-015 Throughput SHALL be one operand per run. There is no operand buffering.

Reset
REQ-016 When RST=0, asynchronously: state=IDLE, in_ready=0, out_valid=0, out_data=0, out_flags=0, core_A=0, core_RST=0, and all counters=0.
REQ-017 On the first clock after RST deasserts: in_ready=1 and core_RST=1.
REQ-018 Reset during CLEAR, RUN or HOLD SHALL abort the run and discard any pending result.

Configuration
REQ-019 With SQRT_WATCHDOG_EN defined:
- An 8-bit cycle counter SHALL run in RUN.
- On reaching TIMEOUT, the block SHALL go to HOLD with out_data=0x7FC00000 and out_flags=0001.
REQ-020 Without SQRT_WATCHDOG_EN:
- No watchdog logic SHALL exist.
- RUN SHALL wait indefinitely.
- out_flags[0] SHALL be tied to 0.

Verification
REQ-021 Send in_data=0x40800000 (4.0) with core model result 0x40000000 after 20 cycles, out_ready=1 -> core_RST low exactly 2 cycles, out_data=0x40000000, out_flags=0000, then in_ready=1.
REQ-022 Send in_data=0xC0800000 -> out_valid 2 cycles after accept, out_data=0x7FC00000, out_flags=1000, core_RST never low.
REQ-023 Send 0x80000000, then 0x7F800000, then 0x00000001 -> outputs 0x80000000/0000, then 0x7F800000/0000, then 0x00000000/0010.
REQ-024 Hold out_ready=0 for 10 cycles in HOLD while in_valid=1 -> out_data stable, in_ready=0, no second accept; release -> single handshake.
REQ-025 Assert RST mid-RUN -> all outputs at reset values immediately, and a subsequent operand completes normally.
REQ-026 With SQRT_WATCHDOG_EN defined and core_enable stuck at 0 -> out_data=0x7FC00000, out_flags=0001 at TIMEOUT+CLR_CYCLES+2 cycles after accept.
